mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port memory interface between the IF-stage fetch port and the MEM-stage data port.
//   One outstanding memory transaction at a time; data requests have priority over fetches.
//   Raises stall_req to the stall controller while any request is still unserved.
//   Cancels in-flight fetches on exception flush.
// PARAMETERS
//   ADDR_W   32   address width, both requesters and the memory side
//   DATA_W   32   data width
//   CNT_W    32   perf-counter width (used only with ARB_PERF_CNT_EN)
// PORTS
//   clk          in   1        clock
//   rst          in   1        synchronous, active-high reset
//   if_req       in   1        fetch request; held until if_valid
//   if_addr      in   ADDR_W   fetch address
//   if_rdata     out  DATA_W   fetched instruction; held until the next if_valid
//   if_valid     out  1        one-cycle pulse: if_rdata is valid
//   d_req        in   1        data request; held until d_valid
//   d_we         in   4        byte write enables; 4'b0000 = load
//   d_addr       in   ADDR_W   data address
//   d_wdata      in   DATA_W   store data
//   d_rdata      out  DATA_W   load data; held until the next d_valid
//   d_valid      out  1        one-cycle pulse: access is complete
//   flush        in   1        exception flush from CP0
//   stall_req    out  1        pipeline stall request
//   m_req        out  1        memory request
//   m_we         out  4        memory byte enables
//   m_addr       out  ADDR_W   memory address
//   m_wdata      out  DATA_W   memory write data
//   m_gnt        in   1        memory accepted m_req this cycle
//   m_rvalid     in   1        read data / write acknowledge; earliest 1 cycle after m_gnt
//   m_rdata      in   DATA_W   memory read data
//   conf_cnt     out  CNT_W    cycles with if_req & d_req both pending (0 without the macro)
//   stall_cnt    out  CNT_W    cycles with stall_req=1 (0 without the macro)
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0, including both counters.
//   - FSM states: IDLE, REQ, WAIT.
//   - Owner register: I (fetch) or D (data). Cancel bit: cancel.
//   - IDLE:
//       - if d_req: latch d_* into the m_* registers, owner=D, go to REQ.
//       - else if if_req & !flush: latch if_addr, m_we=0, owner=I, go to REQ.
//   - REQ: m_req=1 with m_* stable. On m_gnt: m_req=0 in the next cycle, go to WAIT.
//   - WAIT: on m_rvalid, capture m_rdata into the owner's rdata register.
//       - If not cancelled, pulse the owner's valid in the next cycle.
//       - Go to IDLE.
//   - Minimum latency: req sampled at t -> m_req at t+1 -> m_gnt at t+1 -> m_rvalid at t+2 -> valid at t+3.
//   - Back-to-back requests take one IDLE cycle between transactions.
//   - Stores also wait for m_rvalid (write acknowledge) before d_valid.
//   - stall_req = (if_req & !if_valid & !flush) | (d_req & !d_valid). Combinational.
//   - Flush with owner I:
//       - in REQ before m_gnt: withdraw m_req next cycle, go to IDLE. Withdrawal is legal before grant.
//       - in REQ with m_gnt in the same cycle, or in WAIT: set cancel. The response is absorbed, if_valid stays 0, cancel clears on entry to IDLE.
//   - Flush with owner D: ignored; committed data accesses always complete.
//   - Simultaneous if_req and d_req in IDLE: D first, then I. Fetch starvation is bounded: one data access per instruction.
//   - Reset mid-transaction: abandons it. The memory shares rst and drops its pending response.
// CONFIGURATION
//   - ARB_PERF_CNT_EN defined: conf_cnt and stall_cnt increment per qualifying cycle, saturate at all-ones, clear on rst.
//   - ARB_PERF_CNT_EN undefined: both ports tied to 0, no counter flops.
// STRUCTURE
//   - defines.v holds: ARB_IDLE/ARB_REQ/ARB_WAIT state encodings, OWNER_I/OWNER_D, WE_NONE (4'b0000).
//   - Sub-module arb_perf_cnt: one saturating counter, instantiated twice under ARB_PERF_CNT_EN.
// TESTING
//   1. Fetch only: if_req at t0, addr 0xBFC00000; m_gnt at t1; m_rvalid at t2, rdata 0x24080001.
//      -> m_req/m_addr at t1; if_valid and if_rdata=0x24080001 at t3; stall_req 1 for t0..t2, 0 at t3.
//   2. Collision: if_req (0xBFC00004) and d_req load (0x80000010) at t0.
//      -> the data access is on m_addr first; d_valid precedes if_valid; conf_cnt>0 with the macro.
//   3. Store: d_we=4'b0011, d_wdata=0x00001234.
//      -> m_we=0011 and m_wdata=0x00001234 until m_gnt; d_valid one cycle after m_rvalid.
//   4. Flush in REQ with m_gnt held 0 -> m_req falls next cycle, state IDLE, no if_valid.
//   5. Flush in WAIT (fetch) -> m_rvalid absorbed, if_valid never pulses.
//      Same flush during a data access -> d_valid still pulses.
//   6. rst asserted in WAIT -> next cycle m_req=0, valids=0, state IDLE, counters 0.
//      A new if_req is then served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, owner and write-enable encodings for the memory port arbiter
// Contents:
//   arb_state_e  ARB_IDLE / ARB_REQ / ARB_WAIT transaction phases
//   owner_e      OWNER_I (fetch port) / OWNER_D (data port)
//   WE_NONE      byte-enable pattern of a read
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_perf_cnt.sv
// arb_perf_cnt: saturating event counter
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high clear
//   inc_i  in   count this cycle
//   cnt_o  out  W-bit count, sticks at all-ones
module arb_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (inc_i && !(&cnt_q))
            cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port and the data port
// One transaction in flight at a time, data before fetch, fetches cancelled by flush.
// Optional feature: define ARB_PERF_CNT_EN to enable the conf_cnt / stall_cnt counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_rdata/if_valid             fetched word, one-cycle valid pulse
//   d_req/d_we/d_addr/d_wdata     data request (held until d_valid), d_we=0 is a load
//   d_rdata/d_valid               load data, one-cycle completion pulse
//   flush                         exception flush, cancels fetches only
//   stall_req                     some request is still unserved
//   m_req/m_we/m_addr/m_wdata     memory request side
//   m_gnt/m_rvalid/m_rdata        memory grant and response
//   conf_cnt/stall_cnt            perf counters (zero unless ARB_PERF_CNT_EN)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              flush,
    output logic              stall_req,
    output logic              m_req,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [CNT_W-1:0]  conf_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              cancel_q, cancel_d;
    logic [3:0]        m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              d_pend, if_pend, fetch_flush;

    // A request is still high during its own valid cycle; masking with the valid
    // pulse keeps that cycle from launching a duplicate transaction.
    assign d_pend      = d_req & ~d_valid_q;
    assign if_pend     = if_req & ~if_valid_q & ~flush;
    assign fetch_flush = (owner_q == OWNER_I) & flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_I;
            cancel_q   <= 1'b0;
            m_we_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cancel_q   <= cancel_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cancel_d   = cancel_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cancel_d = 1'b0;
                if (d_pend) begin
                    state_d   = ARB_REQ;
                    owner_d   = OWNER_D;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (if_pend) begin
                    state_d  = ARB_REQ;
                    owner_d  = OWNER_I;
                    m_we_d   = WE_NONE;
                    m_addr_d = if_addr;
                end
            end
            ARB_REQ: begin
                // Once granted the memory will answer, so a flush can only mark
                // the fetch as cancelled; before grant it may simply be withdrawn.
                if (m_gnt) begin
                    state_d  = ARB_WAIT;
                    cancel_d = fetch_flush;
                end else if (fetch_flush) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                cancel_d = cancel_q | fetch_flush;
                if (m_rvalid) begin
                    state_d  = ARB_IDLE;
                    cancel_d = 1'b0;
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = m_rdata;
                        d_valid_d = 1'b1;
                    end else if (!(cancel_q | flush)) begin
                        if_rdata_d = m_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign m_req     = (state_q == ARB_REQ);
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign stall_req = (if_req & ~if_valid_q & ~flush) | (d_req & ~d_valid_q);

`ifdef ARB_PERF_CNT_EN
    arb_perf_cnt #(.W(CNT_W)) u_conf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (if_req & d_req),
        .cnt_o (conf_cnt)
    );

    arb_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_req),
        .cnt_o (stall_cnt)
    );
`else
    assign conf_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, if_req, d_req, flush, m_gnt, m_rvalid, sat_inc;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_we;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, conf_cnt, stall_cnt;
    logic        if_valid, d_valid, stall_req, m_req;
    logic [3:0]  m_we;
    logic [2:0]  sat_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .flush(flush), .stall_req(stall_req),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .conf_cnt(conf_cnt), .stall_cnt(stall_cnt)
    );

    arb_perf_cnt #(.W(3)) u_sat (.clk(clk), .rst(rst), .inc_i(sat_inc), .cnt_o(sat_cnt));

    int checks = 0;
    int errors = 0;

    // Transaction-level model: the one memory access in flight and what it has seen so far.
    bit          busy, own_d, granted, cancelled;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_we;
    bit          e_if_valid, e_d_valid;
    logic [31:0] e_if_rdata, e_d_rdata;
    longint      e_conf, e_stall;
    logic [31:0] mem [16];
    int          n_if, n_d;

    function automatic void cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endfunction

    function automatic bit stall_now();
        return (if_req && !e_if_valid && !flush) || (d_req && !e_d_valid);
    endfunction

    function automatic logic [63:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(v);
    endfunction

    task automatic model_step();
        bit niv = 0, ndv = 0;
        if (rst) begin
            busy = 0; granted = 0; cancelled = 0;
            e_if_valid = 0; e_d_valid = 0; e_if_rdata = 0; e_d_rdata = 0;
            e_conf = 0; e_stall = 0;
        end else begin
            if (if_req && d_req) e_conf++;
            if (stall_now()) e_stall++;
            if (!busy) begin
                if (d_req && !e_d_valid) begin
                    busy = 1; own_d = 1; granted = 0; cancelled = 0;
                    t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
                end else if (if_req && !e_if_valid && !flush) begin
                    busy = 1; own_d = 0; granted = 0; cancelled = 0;
                    t_addr = if_addr; t_we = 4'b0000;
                end
            end else if (!granted) begin
                if (m_gnt) begin
                    granted = 1;
                    cancelled = !own_d && flush;
                end else if (!own_d && flush) begin
                    busy = 0;
                end
            end else begin
                if (!own_d && flush) cancelled = 1;
                if (m_rvalid) begin
                    busy = 0;
                    if (own_d) begin
                        ndv = 1; e_d_rdata = m_rdata; n_d++;
                        for (int b = 0; b < 4; b++)
                            if (t_we[b]) mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
                    end else if (!cancelled) begin
                        niv = 1; e_if_rdata = m_rdata; n_if++;
                    end
                end
            end
            e_if_valid = niv;
            e_d_valid = ndv;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check();
        bit exp_req;
        @(negedge clk);
        exp_req = busy && !granted;
        cmp("m_req", m_req, exp_req);
        if (exp_req) begin
            cmp("m_addr", m_addr, t_addr);
            cmp("m_we", m_we, t_we);
            if (own_d) cmp("m_wdata", m_wdata, t_wdata);
        end
        cmp("if_valid", if_valid, e_if_valid);
        cmp("d_valid", d_valid, e_d_valid);
        cmp("if_rdata", if_rdata, e_if_rdata);
        cmp("d_rdata", d_rdata, e_d_rdata);
        cmp("stall_req", stall_req, stall_now());
`ifdef ARB_PERF_CNT_EN
        cmp("conf_cnt", conf_cnt, sat32(e_conf));
        cmp("stall_cnt", stall_cnt, sat32(e_stall));
`else
        cmp("conf_cnt", conf_cnt, 0);
        cmp("stall_cnt", stall_cnt, 0);
`endif
    endtask

    initial begin
        rst = 1; if_req = 0; d_req = 0; flush = 0; m_gnt = 0; m_rvalid = 0; sat_inc = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_we = 0; m_rdata = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        tick(); check();
        cmp("rst_m_req", m_req, 0);
        cmp("rst_stall_cnt", stall_cnt, 0);
        tick(); rst = 0;

        // fetch only, minimum latency
        if_req = 1; if_addr = 32'hBFC0_0000;
        check(); cmp("t1_stall_t0", stall_req, 1);
        tick(); m_gnt = 1;
        check(); cmp("t1_m_req", m_req, 1); cmp("t1_m_addr", m_addr, 32'hBFC0_0000);
        tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h2408_0001;
        check(); cmp("t1_req_drop", m_req, 0); cmp("t1_stall_t2", stall_req, 1);
        tick(); m_rvalid = 0;
        check(); cmp("t1_if_valid", if_valid, 1); cmp("t1_if_rdata", if_rdata, 32'h2408_0001);
        cmp("t1_stall_t3", stall_req, 0);
        tick(); if_req = 0; check();

        // collision: data first, then fetch
        tick(); if_req = 1; if_addr = 32'hBFC0_0004; d_req = 1; d_we = 0; d_addr = 32'h8000_0010;
        check();
        tick(); m_gnt = 1;
        check(); cmp("t2_d_first", m_addr, 32'h8000_0010);
        tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hAAAA_5555;
        check();
        tick(); m_rvalid = 0; d_req = 0;
        check(); cmp("t2_d_valid", d_valid, 1); cmp("t2_no_if_yet", if_valid, 0);
        tick(); m_gnt = 1;
        check(); cmp("t2_i_second", m_addr, 32'hBFC0_0004);
        tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0000;
        check();
        tick(); m_rvalid = 0;
        check(); cmp("t2_if_valid", if_valid, 1);
`ifdef ARB_PERF_CNT_EN
        cmp("t2_conf_nz", conf_cnt != 0, 1);
`endif
        tick(); if_req = 0; check();

        // store with slow grant
        tick(); d_req = 1; d_we = 4'b0011; d_wdata = 32'h0000_1234; d_addr = 32'h8000_0020;
        check();
        tick(); check(); cmp("t3_m_we", m_we, 4'b0011); cmp("t3_m_wdata", m_wdata, 32'h0000_1234);
        tick(); m_gnt = 1;
        check(); cmp("t3_hold_we", m_we, 4'b0011);
        tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h5A5A_0000;
        check(); cmp("t3_no_valid_yet", d_valid, 0);
        tick(); m_rvalid = 0;
        check(); cmp("t3_d_valid", d_valid, 1);
        tick(); d_req = 0;
        check(); cmp("t3_no_dup", m_req, 0);

        // flush before grant withdraws the fetch
        tick(); if_req = 1; if_addr = 32'hBFC0_0008;
        check();
        tick(); flush = 1;
        check(); cmp("t4_m_req", m_req, 1); cmp("t4_stall_flush", stall_req, 0);
        tick(); flush = 0; if_req = 0;
        check(); cmp("t4_withdrawn", m_req, 0);
        tick(); check(); cmp("t4_no_if_valid", if_valid, 0);

        // flush in WAIT: fetch absorbed, data still completes
        tick(); if_req = 1; if_addr = 32'hBFC0_000C;
        check();
        tick(); m_gnt = 1; check();
        tick(); m_gnt = 0; flush = 1; check();
        tick(); flush = 0; if_req = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; check();
        tick(); m_rvalid = 0;
        check(); cmp("t5_absorbed", if_valid, 0);
        tick(); d_req = 1; d_we = 0; d_addr = 32'h8000_0010;
        check();
        tick(); m_gnt = 1; check();
        tick(); m_gnt = 0; flush = 1; m_rvalid = 1; m_rdata = 32'h1234_5678; check();
        tick(); flush = 0; m_rvalid = 0;
        check(); cmp("t5_d_valid", d_valid, 1); cmp("t5_d_rdata", d_rdata, 32'h1234_5678);
        tick(); d_req = 0; check();

        // reset mid-transaction, then a normal fetch
        tick(); if_req = 1; if_addr = 32'hBFC0_0010;
        check();
        tick(); m_gnt = 1; check();
        tick(); m_gnt = 0; rst = 1; check();
        tick(); rst = 0;
        check(); cmp("t6_m_req", m_req, 0); cmp("t6_if_valid", if_valid, 0);
        cmp("t6_conf_cnt", conf_cnt, 0);
        tick(); m_gnt = 1;
        check(); cmp("t6_restart", m_addr, 32'hBFC0_0010);
        tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h3C1D_8000; check();
        tick(); m_rvalid = 0;
        check(); cmp("t6_if_rdata", if_rdata, 32'h3C1D_8000);
        tick(); if_req = 0; check();

        // saturating counter boundary
        sat_inc = 1;
        repeat (3) begin tick(); check(); end
        cmp("sat_3", sat_cnt, 3);
        repeat (6) begin tick(); check(); end
        cmp("sat_hold", sat_cnt, 7);
        sat_inc = 0;

        // randomized traffic
        n_if = 0; n_d = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                if_req = 0; d_req = 0; flush = 0; m_gnt = 0; m_rvalid = 0;
            end else begin
                if (!(if_req && !e_if_valid)) begin
                    if_req = $urandom_range(0, 1) == 1;
                    if_addr = 32'hBFC0_0000 | (32'($urandom_range(0, 15)) << 2);
                end
                flush = ($urandom_range(0, 7) == 0);
                if (flush) if_addr = 32'hBFC0_0380 | (32'($urandom_range(0, 15)) << 2);
                if (!(d_req && !e_d_valid)) begin
                    d_req = ($urandom_range(0, 2) == 0);
                    d_addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
                    d_we = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
                    d_wdata = $urandom;
                end
                m_gnt = (busy && !granted) ? ($urandom_range(0, 1) == 1) : 1'b0;
                m_rvalid = (busy && granted) ? ($urandom_range(0, 1) == 1) : 1'b0;
                m_rdata = (busy && !(own_d && t_we != 0)) ? mem[t_addr[5:2]] : $urandom;
            end
            check();
        end
        cmp("rand_fetch_progress", n_if > 20, 1);
        cmp("rand_data_progress", n_d > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
